// File: rtl/spn_iter_core.sv
// Iterative SPN encryption core: ROUNDS rounds of key-add, S-box substitution and
// one-word rotation, sharing SBOX_N external combinational S-box lanes across the state.
module spn_iter_core #(
    parameter int WORD_W    = 9,
    parameter int WORDS     = 4,
    parameter int KEY_WORDS = 16,
    parameter int SBOX_N    = 2,
    parameter int ROUNDS    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_load,
    input  logic [WORD_W*KEY_WORDS-1:0]       key_in,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WORD_W*WORDS-1:0]           din,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WORD_W*WORDS-1:0]           dout,
    output logic [SBOX_N*WORD_W-1:0]          sbox_x,
    input  logic [SBOX_N*WORD_W-1:0]          sbox_y,
    output logic [$clog2(ROUNDS+1)-1:0]       round_no,
    output logic                              busy
);
    localparam int STATE_W = WORD_W * WORDS;
    localparam int KEY_W   = WORD_W * KEY_WORDS;
    localparam int SUB_CYC = WORDS / SBOX_N;
    localparam int SC_W    = (SUB_CYC > 1) ? $clog2(SUB_CYC) : 1;
    localparam int RN_W    = $clog2(ROUNDS + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ADD  = 3'd1;
    localparam logic [2:0] SUB  = 3'd2;
    localparam logic [2:0] ROT  = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    logic [2:0]         st_q, st_d;
    logic [STATE_W-1:0] s_q, s_d;
    logic [KEY_W-1:0]   mk_q, mk_d;
    logic [KEY_W-1:0]   wk_q, wk_d;
    logic [SC_W-1:0]    sc_q, sc_d;
    logic [RN_W-1:0]    rn_q, rn_d;
    logic [STATE_W-1:0] rk;
    logic               accept;

    assign rk        = wk_q[KEY_W-1 -: STATE_W];
    assign in_ready  = (st_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign busy      = (st_q != IDLE);
    assign out_valid = (st_q == DONE);
    assign dout      = out_valid ? s_q : '0;
    assign round_no  = rn_q;

    // Lane l carries word sc_q*SBOX_N+l; idle lanes are held at zero.
    always_comb begin
        sbox_x = '0;
        if (st_q == SUB) begin
            for (int w = 0; w < WORDS; w++) begin
                if (w / SBOX_N == int'(sc_q))
                    sbox_x[(w % SBOX_N)*WORD_W +: WORD_W] = s_q[w*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        st_d = st_q;
        s_d  = s_q;
        mk_d = mk_q;
        wk_d = wk_q;
        sc_d = sc_q;
        rn_d = rn_q;
        case (st_q)
            IDLE: begin
                if (key_load) mk_d = key_in;
                if (accept) begin
                    s_d  = din;
                    wk_d = key_load ? key_in : mk_q;
                    rn_d = '0;
                    sc_d = '0;
                    st_d = ADD;
                end
            end
            ADD: begin
                s_d  = s_q ^ rk;
                wk_d = {wk_q[KEY_W-STATE_W-1:0], wk_q[KEY_W-1 -: STATE_W]};
                sc_d = '0;
                st_d = SUB;
            end
            SUB: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (w / SBOX_N == int'(sc_q))
                        s_d[w*WORD_W +: WORD_W] = sbox_y[(w % SBOX_N)*WORD_W +: WORD_W];
                end
                if (int'(sc_q) == SUB_CYC - 1) st_d = ROT;
                else                           sc_d = sc_q + 1'b1;
            end
            ROT: begin
                s_d  = {s_q[STATE_W-WORD_W-1:0], s_q[STATE_W-1 -: WORD_W]};
                rn_d = rn_q + 1'b1;
                st_d = (int'(rn_q) < ROUNDS - 1) ? ADD : FIN;
            end
            FIN: begin
                s_d  = s_q ^ rk;
                st_d = DONE;
            end
            DONE: begin
                if (out_ready) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= IDLE;
            s_q  <= '0;
            mk_q <= '0;
            wk_q <= '0;
            sc_q <= '0;
            rn_q <= '0;
        end else begin
            st_q <= st_d;
            s_q  <= s_d;
            mk_q <= mk_d;
            wk_q <= wk_d;
            sc_q <= sc_d;
            rn_q <= rn_d;
        end
    end
endmodule

// File: tb/tb_spn_iter_core.sv
// Bench for spn_iter_core: fixed vectors, randomized blocks against a word-array
// reference model, and hand sequences for back-pressure, key timing and mid-block reset.
module tb_spn_iter_core;
    localparam int LAT = 33;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_load;
    logic [143:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic [35:0]  din;
    logic         out_valid;
    logic         out_ready;
    logic [35:0]  dout;
    logic [17:0]  sbox_x;
    logic [17:0]  sbox_y;
    logic [3:0]   round_no;
    logic         busy;

    logic         key_load2;
    logic [143:0] key_in2;
    logic         in_valid2;
    logic         in_ready2;
    logic [35:0]  din2;
    logic         out_valid2;
    logic         out_ready2;
    logic [35:0]  dout2;
    logic [17:0]  sbox_x2;
    logic [17:0]  sbox_y2;
    logic [0:0]   round_no2;
    logic         busy2;

    int           sb_mode;
    int           n_chk = 0;
    int           n_fail = 0;
    logic [35:0]  post_add [8];

    always #5 clk = ~clk;

    spn_iter_core dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
        .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .sbox_x(sbox_x), .sbox_y(sbox_y), .round_no(round_no), .busy(busy)
    );

    spn_iter_core #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .key_load(key_load2), .key_in(key_in2),
        .in_valid(in_valid2), .in_ready(in_ready2), .din(din2),
        .out_valid(out_valid2), .out_ready(out_ready2), .dout(dout2),
        .sbox_x(sbox_x2), .sbox_y(sbox_y2), .round_no(round_no2), .busy(busy2)
    );

    function automatic logic [8:0] sb(input int m, input logic [8:0] x);
        logic [17:0] p;
        p = {9'b0, x} * {9'b0, x};
        if (m == 0)      return x;
        else if (m == 1) return x ^ 9'h1FF;
        else             return p[8:0] ^ {x[3:0], x[8:4]} ^ 9'h0A5;
    endfunction

    always_comb begin
        sbox_y = '0;
        for (int l = 0; l < 2; l++) sbox_y[l*9 +: 9] = sb(sb_mode, sbox_x[l*9 +: 9]);
    end
    assign sbox_y2 = sbox_x2;

    // Reference: the key is read as four 36-bit round-key slices used cyclically from the top.
    function automatic logic [35:0] model(input logic [35:0] d, input logic [143:0] k, input int m);
        logic [8:0]  w [4];
        logic [8:0]  t [4];
        logic [35:0] rk;
        for (int i = 0; i < 4; i++) w[i] = d[i*9 +: 9];
        for (int r = 0; r < 8; r++) begin
            rk = k[143 - (r % 4)*36 -: 36];
            for (int i = 0; i < 4; i++) w[i] = w[i] ^ rk[i*9 +: 9];
            post_add[r] = {w[3], w[2], w[1], w[0]};
            for (int i = 0; i < 4; i++) t[(i + 1) % 4] = sb(m, w[i]);
            w = t;
        end
        rk = k[143 -: 36];
        return {w[3], w[2], w[1], w[0]} ^ rk;
    endfunction

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_key(input logic [143:0] k);
        key_load = 1'b1;
        key_in   = k;
        @(posedge clk); @(negedge clk);
        key_load = 1'b0;
    endtask

    task automatic run_block(input string nm, input logic [35:0] d, input logic kl,
                             input logic [143:0] k, input logic [35:0] exp, input logic chk_sb,
                             input int hold, input logic kl_busy, input logic [143:0] kb);
        int lat;
        int g;
        logic [17:0] ex_x;
        g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); @(negedge clk); g++;
        end
        chk({nm, " in_ready"}, 144'(in_ready), 144'(1'b1));
        in_valid = 1'b1; din = d; key_load = kl; key_in = k;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; key_load = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (chk_sb) begin
                ex_x = '0;
                if (lat < 32 && lat % 4 == 1) ex_x = post_add[lat/4][17:0];
                if (lat < 32 && lat % 4 == 2) ex_x = post_add[lat/4][35:18];
                chk($sformatf("%s sbox_x@%0d", nm, lat), 144'(sbox_x), 144'(ex_x));
                chk($sformatf("%s round_no@%0d", nm, lat), 144'(round_no),
                    144'((lat < 32) ? lat/4 : 8));
            end
            din      = 36'({$urandom, $urandom});
            key_in   = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
            in_valid = (lat >= 8 && lat < 12);
            key_load = kl_busy && (lat == 5);
            if (key_load) key_in = kb;
            @(posedge clk); @(negedge clk);
            lat++;
        end
        in_valid = 1'b0; key_load = 1'b0;
        chk({nm, " latency"}, 144'(lat), 144'(LAT));
        chk({nm, " dout"}, 144'(dout), 144'(exp));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
            chk($sformatf("%s hold out_valid@%0d", nm, h), 144'(out_valid), 144'(1'b1));
            chk($sformatf("%s hold dout@%0d", nm, h), 144'(dout), 144'(exp));
            chk($sformatf("%s hold in_ready@%0d", nm, h), 144'(in_ready), 144'(1'b0));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " post out_valid"}, 144'(out_valid), 144'(1'b0));
        chk({nm, " post busy"}, 144'(busy), 144'(1'b0));
        chk({nm, " post in_ready"}, 144'(in_ready), 144'(1'b1));
    endtask

    typedef struct {
        logic [35:0]  din;
        logic [143:0] key;
        int           mode;
        logic [35:0]  exp;
    } vec_t;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [5];
        logic [35:0]  d, e;
        logic [143:0] ka, kbk;
        int           lat;

        tbl[0] = '{36'h123456789, 144'h0, 0, 36'h123456789};
        tbl[1] = '{36'h0, {144{1'b1}}, 0, 36'hFFFFFFFFF};
        tbl[2] = '{36'h0, {36'h0000001FF, 108'h0}, 0, 36'h0000001FF};
        tbl[3] = '{36'hABCDEF012, 144'h0, 1, 36'hABCDEF012};
        tbl[4] = '{36'h5A5A0F0F3, 144'h0123456789ABCDEF0011223344556677_8899, 2, 36'h0};
        tbl[4].exp = model(tbl[4].din, tbl[4].key, 2);

        sb_mode = 0;
        rst = 1'b1; key_load = 1'b0; key_in = '0; in_valid = 1'b0; din = '0; out_ready = 1'b0;
        key_load2 = 1'b0; key_in2 = '0; in_valid2 = 1'b0; din2 = '0; out_ready2 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("reset in_ready", 144'(in_ready), 144'(1'b0));
        chk("reset out_valid", 144'(out_valid), 144'(1'b0));
        chk("reset dout", 144'(dout), 144'(0));
        chk("reset sbox_x", 144'(sbox_x), 144'(0));
        chk("reset round_no", 144'(round_no), 144'(0));
        chk("reset busy", 144'(busy), 144'(1'b0));
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("after reset in_ready", 144'(in_ready), 144'(1'b1));

        for (int i = 0; i < 5; i++) begin
            sb_mode = tbl[i].mode;
            run_block($sformatf("vec%0d", i), tbl[i].din, 1'b1, tbl[i].key, tbl[i].exp,
                      1'b0, 0, 1'b0, '0);
        end

        // S-box lane order and round counter, inverting S-box
        sb_mode = 1;
        d  = 36'({$urandom, $urandom});
        ka = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
        e  = model(d, ka, 1);
        run_block("sbox_order", d, 1'b1, ka, e, 1'b1, 0, 1'b0, '0);

        sb_mode = 2;
        for (int i = 0; i < 6; i++) begin
            d  = 36'({$urandom, $urandom});
            ka = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
            e  = model(d, ka, 2);
            if (i % 2 == 0) begin
                run_block($sformatf("rand%0d", i), d, 1'b1, ka, e, 1'b0, 0, 1'b0, '0);
            end else begin
                load_key(ka);
                run_block($sformatf("rand%0d", i), d, 1'b0, '0, e, 1'b0, 0, 1'b0, '0);
            end
        end

        // Back-pressure: hold out_ready low for 10 cycles
        d  = 36'h0F1E2D3C4;
        ka = 144'h00FF00FF00FF00FF_1234567890ABCDEF_CAFE;
        run_block("hold", d, 1'b1, ka, model(d, ka, 2), 1'b0, 10, 1'b0, '0);

        // key_load while busy is ignored; key_load in IDLE takes effect
        ka  = 144'h1111_2222_3333_4444_5555_6666_7777_8888_9999;
        kbk = 144'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123_4567_89AB;
        load_key(ka);
        d = 36'h13579BDF0;
        run_block("kl_busy", d, 1'b0, '0, model(d, ka, 2), 1'b0, 0, 1'b1, kbk);
        d = 36'h2468ACE13;
        run_block("kl_next_old", d, 1'b0, '0, model(d, ka, 2), 1'b0, 0, 1'b0, '0);
        load_key(kbk);
        d = 36'h3C3C3C3C3;
        run_block("kl_idle_new", d, 1'b0, '0, model(d, kbk, 2), 1'b0, 0, 1'b0, '0);

        // Reset during round 3 aborts the block and clears the master key
        in_valid = 1'b1; din = 36'h777777777;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (13) begin @(posedge clk); @(negedge clk); end
        chk("pre-rst round_no", 144'(round_no), 144'(3));
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst in_ready", 144'(in_ready), 144'(1'b0));
        chk("midrst out_valid", 144'(out_valid), 144'(1'b0));
        chk("midrst dout", 144'(dout), 144'(0));
        chk("midrst sbox_x", 144'(sbox_x), 144'(0));
        chk("midrst round_no", 144'(round_no), 144'(0));
        chk("midrst busy", 144'(busy), 144'(1'b0));
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        d = 36'h89ABCDEF1;
        run_block("after_rst_key0", d, 1'b0, '0, model(d, 144'h0, 2), 1'b0, 0, 1'b0, '0);
        run_block("after_rst_key", d, 1'b1, ka, model(d, ka, 2), 1'b0, 0, 1'b0, '0);

        // Single-round core, identity S-box
        in_valid2 = 1'b1; din2 = '0; key_load2 = 1'b1; key_in2 = {36'h0000001FF, 108'h0};
        @(posedge clk); @(negedge clk);
        in_valid2 = 1'b0; key_load2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 50) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        chk("r1 latency", 144'(lat), 144'(5));
        chk("r1 dout", 144'(dout2), 144'(36'h00003FE00));
        chk("r1 round_no", 144'(round_no2), 144'(1));
        out_ready2 = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready2 = 1'b0;
        chk("r1 idle", 144'(busy2), 144'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
